// File: rtl/usb_pkg.sv
// Shared constants and types for the USB full-speed packet transmitter.
package usb_pkg;

  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // CRC16 held bit-reflected so the complemented register shifts out LSB first.
  localparam logic [15:0] CRC16_POLY    = 16'hA001;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'hB001;

  typedef enum logic [1:0] {
    CMD_ACK   = 2'd0,
    CMD_NAK   = 2'd1,
    CMD_STALL = 2'd2,
    CMD_DATA  = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_e;

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial USB CRC16 over payload bits, one bit per enable, reflected register.
module usb_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] state,
  output logic [15:0] crc_out
);

  logic [15:0] state_q;
  logic [15:0] state_d;
  logic        fb;

  assign fb = bit_in ^ state_q[0];

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = CRC16_INIT;
    end else if (en) begin
      state_d = (state_q >> 1) ^ (fb ? CRC16_POLY : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CRC16_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  assign state   = state_q;
  assign crc_out = ~state_q;

endmodule

// File: rtl/usb_tx_engine.sv
// USB full-speed packet transmitter: SYNC, PID, optional payload + CRC16, EOP,
// NRZI-encoded with bit stuffing at CLKS_PER_BIT clocks per line bit.
module usb_tx_engine
  import usb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned MAX_PAYLOAD  = 64,
  parameter int unsigned STUFF_LEN    = 6,
  parameter int unsigned LEN_W        = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_type,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  input  logic             toggle_clr,
  input  logic [7:0]       fifo_byte,
  input  logic             fifo_ready,
  output logic             fifo_r_enable,
  output logic             tx_d_plus,
  output logic             tx_d_minus,
  output logic             is_txing,
  output logic             done,
  output logic             underflow
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned OW = $clog2(STUFF_LEN + 1);
  localparam logic [TW-1:0]    TC_VAL   = TW'(CLKS_PER_BIT - 1);
  localparam logic [OW-1:0]    STUFF_AT = OW'(STUFF_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_PAYLOAD);

  tx_state_e        state_q, state_d;
  logic [TW-1:0]    timer_q;
  logic [2:0]       idx_q, idx_d;
  logic [OW-1:0]    ones_q;
  logic [7:0]       shift_q, byte_d, pid_q;
  logic [LEN_W-1:0] len_q, cnt_q, cnt_d;
  logic             is_data_q, toggle_q;
  logic             dp_q, dm_q, txing_q, pop_q, under_q, done_q;
  logic             tc, stuff, bit_state, fetch, bit_d, pop_d, under_d;
  logic             crc_clr, crc_en;
  logic [15:0]      crc_out, crc_state_unused;

  assign tc        = (timer_q == TC_VAL);
  assign stuff     = (ones_q == STUFF_AT);
  assign bit_state = state_q inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI};

  // Next bit position, byte source and state once the current bit completes.
  always_comb begin
    state_d = state_q;
    byte_d  = shift_q;
    idx_d   = idx_q + 3'd1;
    cnt_d   = cnt_q;
    pop_d   = 1'b0;
    under_d = 1'b0;
    fetch   = 1'b0;
    if (idx_q == 3'd7) begin
      idx_d = '0;
      case (state_q)
        ST_SYNC: begin
          state_d = ST_PID;
          byte_d  = pid_q;
        end
        ST_PID: begin
          if (!is_data_q) begin
            state_d = ST_EOP_SE0;
          end else if (len_q == '0) begin
            state_d = ST_CRC_LO;
            byte_d  = crc_out[7:0];
          end else begin
            fetch = 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q == len_q) begin
            state_d = ST_CRC_LO;
            byte_d  = crc_out[7:0];
          end else begin
            fetch = 1'b1;
          end
        end
        ST_CRC_LO: begin
          state_d = ST_CRC_HI;
          byte_d  = crc_out[15:8];
        end
        ST_CRC_HI: state_d = ST_EOP_SE0;
        default: ;
      endcase
      if (fetch) begin
        if (fifo_ready) begin
          state_d = ST_DATA;
          byte_d  = fifo_byte;
          pop_d   = 1'b1;
          cnt_d   = cnt_q + LEN_W'(1);
        end else begin
          state_d = ST_EOP_SE0;
          under_d = 1'b1;
        end
      end
    end
    bit_d = byte_d[idx_d];
  end

  assign crc_clr = (state_q == ST_IDLE) && cmd_valid;
  assign crc_en  = bit_state && tc && !stuff && (state_d == ST_DATA);

  usb_crc16 u_crc (
    .clk     (clk),
    .rst     (rst),
    .clr     (crc_clr),
    .en      (crc_en),
    .bit_in  (bit_d),
    .state   (crc_state_unused),
    .crc_out (crc_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      ones_q    <= '0;
      shift_q   <= '0;
      pid_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      is_data_q <= 1'b0;
      toggle_q  <= 1'b0;
      dp_q      <= 1'b1;
      dm_q      <= 1'b0;
      txing_q   <= 1'b0;
      pop_q     <= 1'b0;
      under_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pop_q   <= 1'b0;
      under_q <= 1'b0;
      done_q  <= 1'b0;
      if (state_q != ST_IDLE) begin
        timer_q <= tc ? '0 : timer_q + TW'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            state_q   <= ST_SYNC;
            timer_q   <= '0;
            idx_q     <= '0;
            ones_q    <= '0;
            shift_q   <= SYNC_BYTE;
            dp_q      <= SYNC_BYTE[0];
            dm_q      <= ~SYNC_BYTE[0];
            txing_q   <= 1'b1;
            cnt_q     <= '0;
            len_q     <= (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
            is_data_q <= (cmd_type_e'(cmd_type) == CMD_DATA);
            case (cmd_type_e'(cmd_type))
              CMD_ACK:   pid_q <= pid_byte(PID_ACK);
              CMD_NAK:   pid_q <= pid_byte(PID_NAK);
              CMD_STALL: pid_q <= pid_byte(PID_STALL);
              default:   pid_q <= pid_byte((toggle_q && !toggle_clr) ? PID_DATA1 : PID_DATA0);
            endcase
          end
        end
        ST_EOP_SE0: begin
          if (tc) begin
            if (idx_q == 3'd1) begin
              state_q <= ST_EOP_J;
              idx_q   <= '0;
              dp_q    <= 1'b1;
              dm_q    <= 1'b0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        ST_EOP_J: begin
          if (tc) begin
            state_q <= ST_IDLE;
            txing_q <= 1'b0;
            done_q  <= 1'b1;
            if (is_data_q) toggle_q <= ~toggle_q;
          end
        end
        default: begin
          if (tc) begin
            if (stuff) begin
              dp_q   <= ~dp_q;
              dm_q   <= dp_q;
              ones_q <= '0;
            end else begin
              state_q <= state_d;
              shift_q <= byte_d;
              idx_q   <= idx_d;
              cnt_q   <= cnt_d;
              pop_q   <= pop_d;
              under_q <= under_d;
              if (state_d == ST_EOP_SE0) begin
                dp_q   <= 1'b0;
                dm_q   <= 1'b0;
                ones_q <= '0;
                // An aborted payload must not advance the data toggle at EOP.
                if (under_d) is_data_q <= 1'b0;
              end else if (bit_d) begin
                ones_q <= ones_q + OW'(1);
              end else begin
                dp_q   <= ~dp_q;
                dm_q   <= dp_q;
                ones_q <= '0;
              end
            end
          end
        end
      endcase
      if (toggle_clr) toggle_q <= 1'b0;
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign fifo_r_enable = pop_q;
  assign tx_d_plus     = dp_q;
  assign tx_d_minus    = dm_q;
  assign is_txing      = txing_q;
  assign done          = done_q;
  assign underflow     = under_q;

endmodule
